// File: rtl/conbus_arb5_wd.sv
// conbus_arb5_wd: round-robin grant for the five-master conbus shared bus.
// Grant is held for a master's whole cyc tenure and rotates circularly on release.
// Optional stalled-transfer watchdog is enabled by defining CONBUS_ARB_WD_EN;
// without it wd_err and wd_count are tied to zero and wd_clr is ignored.
module conbus_arb5_wd #(
  parameter int PARK    = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [4:0] req,
  input  logic       stb,
  input  logic       ack,
  output logic [2:0] gnt,
  output logic       wd_err,
  output logic [7:0] wd_count,
  input  logic       wd_clr
);

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  arb_state_t state;
  logic [2:0] gnt_next;
  logic [7:0] req_ext;
  logic       owner_req;
  logic       found;

  // Zero-padded request vector so the 3-bit grant can index it without range issues.
  assign req_ext   = {3'b000, req};
  assign owner_req = req_ext[gnt];

  // Circular index (base + offset) mod 5 for base 0..4, offset 1..5.
  function automatic logic [2:0] rr_index(input logic [2:0] base, input logic [2:0] offset);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end
    return sum[2:0];
  endfunction

  // Decode ownership and pick the next grant: hold while owned, else first requester after gnt.
  always_comb begin
    state    = owner_req ? OWNED : FREE;
    gnt_next = gnt;
    found    = 1'b0;
    if (state == FREE) begin
      for (int i = 1; i <= 5; i++) begin
        if (!found && req_ext[rr_index(gnt, 3'(i))]) begin
          gnt_next = rr_index(gnt, 3'(i));
          found    = 1'b1;
        end
      end
    end
  end

  // Grant register; reset parks the bus on PARK immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt <= 3'(PARK);
    end else begin
      gnt <= gnt_next;
    end
  end

`ifdef CONBUS_ARB_WD_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wdc;
  logic        stall;
  logic        gnt_change;
  logic        wd_event;

  assign stall      = owner_req & stb & ~ack;
  assign gnt_change = (gnt_next != gnt);
  assign wd_event   = stall & ~gnt_change & (wdc == WD_LAST);

  // Stall cycle counter: counts consecutive unacked strobes, restarts on any break or grant move.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdc <= '0;
    end else if (!stall || gnt_change || wd_event) begin
      wdc <= '0;
    end else begin
      wdc <= wdc + 16'd1;
    end
  end

  // One-cycle error pulse the cycle after the stall bound is reached.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_err <= 1'b0;
    end else begin
      wd_err <= wd_event;
    end
  end

  // Saturating event tally; a clear in the same cycle as an event takes priority.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_count <= '0;
    end else if (wd_clr) begin
      wd_count <= '0;
    end else if (wd_event && (wd_count != 8'hFF)) begin
      wd_count <= wd_count + 8'd1;
    end
  end
`else
  logic unused_wd;

  assign wd_err    = 1'b0;
  assign wd_count  = '0;
  assign unused_wd = ^{wd_clr, stb, ack};
`endif

endmodule

// File: tb/tb_conbus_arb5_wd.sv
// Directed self-checking bench for conbus_arb5_wd (PARK=2, TIMEOUT=8).
// Watchdog expectations follow CONBUS_ARB_WD_EN; grant expectations are build-independent.
module tb_conbus_arb5_wd;

`ifdef CONBUS_ARB_WD_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic [4:0] req;
  logic       stb;
  logic       ack;
  logic       wd_clr;
  logic [2:0] gnt;
  logic       wd_err;
  logic [7:0] wd_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  conbus_arb5_wd #(
    .PARK    (2),
    .TIMEOUT (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .stb       (stb),
    .ack       (ack),
    .gnt       (gnt),
    .wd_err    (wd_err),
    .wd_count  (wd_count),
    .wd_clr    (wd_clr)
  );

  // Free-running 10 ns clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] r, input logic s, input logic a, input logic c);
    req    = r;
    stb    = s;
    ack    = a;
    wd_clr = c;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Linear sequence of directed steps.
  initial begin
    apply_stimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check_output("reset_gnt", 32'(gnt), 32'd2);
    check_output("reset_wd_err", 32'(wd_err), 32'd0);
    check_output("reset_wd_count", 32'(wd_count), 32'd0);
    tick(2);
    sys_rst_n = 1'b1;

    // Idle after reset: bus stays parked on PARK.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_output("idle_gnt", 32'(gnt), 32'd2);
      check_output("idle_wd_err", 32'(wd_err), 32'd0);
      check_output("idle_wd_count", 32'(wd_count), 32'd0);
    end

    // Master 0 acquires the bus from park position 2 (search 3,4,0).
    apply_stimulus(5'b00001, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_output("acquire_0", 32'(gnt), 32'd0);
    apply_stimulus(5'b10111, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_output("hold_0", 32'(gnt), 32'd0);

    // Release sequence 0 -> 1 -> 2 -> 4, one handover cycle each.
    apply_stimulus(5'b10110, 1'b0, 1'b0, 1'b0);
    check_output("handover_old_0", 32'(gnt), 32'd0);
    tick(1);
    check_output("rr_to_1", 32'(gnt), 32'd1);
    tick(2);
    check_output("hold_1", 32'(gnt), 32'd1);
    apply_stimulus(5'b10100, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_output("rr_to_2", 32'(gnt), 32'd2);
    apply_stimulus(5'b10000, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_output("rr_to_4", 32'(gnt), 32'd4);

    // Owner 4 releases while master 3 raises in the same cycle (search 0,1,2,3).
    apply_stimulus(5'b01000, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_output("simul_to_3", 32'(gnt), 32'd3);

    // No preemption with all masters requesting.
    apply_stimulus(5'b11111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check_output("no_preempt", 32'(gnt), 32'd3);
    end

    // Continuous stall: pulses after 8 and 16 cycles.
    apply_stimulus(5'b11111, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (WD && (i % 8 == 0)) exp_cnt = sat_inc(exp_cnt);
      check_output("stall_gnt", 32'(gnt), 32'd3);
      check_output("stall_wd_err", 32'(wd_err), 32'(WD && (i % 8 == 0)));
      check_output("stall_wd_count", 32'(wd_count), 32'(exp_cnt));
    end

    // Ack every 7th cycle keeps the stall below the bound.
    for (int i = 1; i <= 40; i++) begin
      apply_stimulus(5'b11111, 1'b1, 1'(i % 7 == 0), 1'b0);
      tick(1);
      check_output("ack7_wd_err", 32'(wd_err), 32'd0);
      check_output("ack7_wd_count", 32'(wd_count), 32'(exp_cnt));
    end

    // Restart the stall counter, then drive 300 events to saturate.
    apply_stimulus(5'b11111, 1'b0, 1'b0, 1'b0);
    tick(1);
    apply_stimulus(5'b11111, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 2400; i++) begin
      tick(1);
      if (WD && (i % 8 == 0)) exp_cnt = sat_inc(exp_cnt);
    end
    check_output("sat_wd_count", 32'(wd_count), WD ? 32'd255 : 32'd0);
    check_output("sat_wd_err", 32'(wd_err), 32'(WD));
    check_output("sat_model", 32'(wd_count), 32'(exp_cnt));

    // Clear coincident with an event wins.
    tick(7);
    check_output("pre_clr_count", 32'(wd_count), 32'(exp_cnt));
    check_output("pre_clr_err", 32'(wd_err), 32'd0);
    apply_stimulus(5'b11111, 1'b1, 1'b0, 1'b1);
    tick(1);
    exp_cnt = 0;
    check_output("clr_wd_err", 32'(wd_err), 32'(WD));
    check_output("clr_wd_count", 32'(wd_count), 32'd0);
    apply_stimulus(5'b11111, 1'b1, 1'b0, 1'b0);
    tick(8);
    if (WD) exp_cnt = 1;
    check_output("post_clr_err", 32'(wd_err), 32'(WD));
    check_output("post_clr_count", 32'(wd_count), 32'(exp_cnt));
    check_output("post_clr_gnt", 32'(gnt), 32'd3);

    // Mid-tenure reset while wd_err is high.
    sys_rst_n = 1'b0;
    #1;
    check_output("midrst_gnt", 32'(gnt), 32'd2);
    check_output("midrst_wd_err", 32'(wd_err), 32'd0);
    check_output("midrst_wd_count", 32'(wd_count), 32'd0);
    apply_stimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(1);
    check_output("after_rst_gnt", 32'(gnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
